// File: rtl/mem64_responder.sv
// Slave end of a 64-bit load/store port: one request at a time, programmable wait,
// read-modify-write sub-word stores, extended loads and an alignment/range error flag.
module mem64_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, COMMIT} state_t;

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic          we_q, uns_q, err_q;
  logic [63:0]   addr_q, wdata_q;
  logic [1:0]    size_q;
  logic          accept;
  logic          misaligned, out_of_range, err_calc;
  logic [AW-1:0] word_idx;
  logic [2:0]    lane;
  logic [7:0]    size_mask, lane_mask;
  logic [63:0]   wdata_sh, rdata_sh, merged, load_val, merge_buf;
  logic [63:0]   mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign word_idx  = addr_q[AW+2:3];
  assign lane      = addr_q[2:0];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY > 0) begin
            state_next = WAIT;
            cnt_next   = LAT_LOAD;
          end else begin
            state_next = ACCESS;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = ACCESS;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ACCESS:  state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lane[0];
      2'd2:    misaligned = |lane[1:0];
      2'd3:    misaligned = |lane;
      default: misaligned = 1'b0;
    endcase
    out_of_range = |addr_q[63:AW+3];
    err_calc     = misaligned | out_of_range;
  end

  // Store merge: covered bytes come from the lane-shifted wdata, the rest from the old word.
  always_comb begin
    case (size_q)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      2'd3:    size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
    lane_mask = size_mask << lane;
    wdata_sh  = wdata_q << {lane, 3'b000};
    merged    = merge_buf;
    for (int i = 0; i < 8; i++) begin
      if (lane_mask[i]) begin
        merged[8*i +: 8] = wdata_sh[8*i +: 8];
      end else begin
        merged[8*i +: 8] = merge_buf[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_sh = merge_buf >> {lane, 3'b000};
    case (size_q)
      2'd0:    load_val = uns_q ? {56'd0, rdata_sh[7:0]}  : {{56{rdata_sh[7]}},  rdata_sh[7:0]};
      2'd1:    load_val = uns_q ? {48'd0, rdata_sh[15:0]} : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      2'd2:    load_val = uns_q ? {32'd0, rdata_sh[31:0]} : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      2'd3:    load_val = rdata_sh;
      default: load_val = 64'd0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      size_q     <= 2'd0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      resp_valid <= (state == COMMIT);
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
      end
      if (state == ACCESS) begin
        err_q <= err_calc;
      end
      if (state == COMMIT) begin
        resp_err   <= err_q;
        resp_rdata <= (we_q || err_q) ? 64'd0 : load_val;
      end
    end
  end

  // Storage is never reset; an aborted request cannot reach COMMIT, so it never writes.
  always_ff @(posedge Clk) begin
    if (state == ACCESS) begin
      merge_buf <= mem[word_idx];
    end
    if (state == COMMIT && we_q && !err_q) begin
      mem[word_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_mem64_responder.sv
// Directed bench: LATENCY=2 instance for function/error/reset, LATENCY=0 instance for back-to-back.
module tb_mem64_responder;

  logic        Clk, Reset;
  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned, a_resp_valid, a_resp_err;
  logic [63:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [1:0]  a_req_size;
  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned, b_resp_valid, b_resp_err;
  logic [63:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [1:0]  b_req_size;

  int total = 0;
  int bad   = 0;

  mem64_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_a (
    .Clk(Clk), .Reset(Reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_size(a_req_size),
    .req_unsigned(a_req_unsigned), .req_wdata(a_req_wdata), .resp_valid(a_resp_valid),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  mem64_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_b (
    .Clk(Clk), .Reset(Reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_size(b_req_size),
    .req_unsigned(b_req_unsigned), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [63:0] addr, input logic [1:0] size,
                     input logic uns, input logic [63:0] wdata,
                     output logic [63:0] rd, output logic er, output int lat);
    @(negedge Clk);
    a_req_we = we; a_req_addr = addr; a_req_size = size;
    a_req_unsigned = uns; a_req_wdata = wdata; a_req_valid = 1'b1;
    @(posedge Clk);
    #1 a_req_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge Clk);
      lat++;
      #1;
      if (a_resp_valid) break;
    end
    rd = a_resp_rdata;
    er = a_resp_err;
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat;
  int          pulses;
  logic [5:0]  rv_bits, rr_bits;
  logic [63:0] rd_first, rd_second;

  initial begin
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 64'd0; a_req_size = 2'd0;
    a_req_unsigned = 1'b0; a_req_wdata = 64'd0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 64'd0; b_req_size = 2'd0;
    b_req_unsigned = 1'b0; b_req_wdata = 64'd0;
    Reset = 1'b1;
    #1;
    chk("rst_ready", {63'd0, a_req_ready}, 64'd1);
    chk("rst_valid", {63'd0, a_resp_valid}, 64'd0);
    chk("rst_rdata", a_resp_rdata, 64'd0);
    chk("rst_err", {63'd0, a_resp_err}, 64'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // Full store then load
    txn(1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788, rd, er, lat);
    chk("st_lat", 64'(lat), 64'd4);
    chk("st_err", {63'd0, er}, 64'd0);
    chk("st_rd", rd, 64'd0);
    txn(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("ld_lat", 64'(lat), 64'd4);
    chk("ld_d", rd, 64'h1122334455667788);

    // Byte merge
    txn(1'b1, 64'h13, 2'd0, 1'b0, 64'hAB, rd, er, lat);
    chk("stb_err", {63'd0, er}, 64'd0);
    txn(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("merge_d", rd, 64'h11223344AB667788);

    // Extension
    txn(1'b0, 64'h13, 2'd0, 1'b0, 64'd0, rd, er, lat);
    chk("ld_b_s", rd, 64'hFFFFFFFFFFFFFFAB);
    txn(1'b0, 64'h13, 2'd0, 1'b1, 64'd0, rd, er, lat);
    chk("ld_b_u", rd, 64'h00000000000000AB);
    txn(1'b0, 64'h12, 2'd1, 1'b0, 64'd0, rd, er, lat);
    chk("ld_h_s", rd, 64'hFFFFFFFFFFFFAB66);
    txn(1'b0, 64'h10, 2'd2, 1'b0, 64'd0, rd, er, lat);
    chk("ld_w_s", rd, 64'hFFFFFFFFAB667788);
    @(posedge Clk);
    #1;
    chk("pulse_1cyc", {63'd0, a_resp_valid}, 64'd0);
    chk("rdata_hold", a_resp_rdata, 64'hFFFFFFFFAB667788);

    // Errors
    txn(1'b0, 64'h12, 2'd2, 1'b0, 64'd0, rd, er, lat);
    chk("mis_w_err", {63'd0, er}, 64'd1);
    chk("mis_w_rd", rd, 64'd0);
    txn(1'b1, 64'h11, 2'd1, 1'b0, 64'hFFFF, rd, er, lat);
    chk("mis_h_err", {63'd0, er}, 64'd1);
    txn(1'b1, 64'h0, 2'd3, 1'b0, 64'hCAFEF00D12345678, rd, er, lat);
    chk("st0_err", {63'd0, er}, 64'd0);
    txn(1'b1, 64'h800, 2'd3, 1'b0, 64'h5555555555555555, rd, er, lat);
    chk("oor_err", {63'd0, er}, 64'd1);
    chk("oor_rd", rd, 64'd0);
    txn(1'b0, 64'h0, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("oor_nowrite", rd, 64'hCAFEF00D12345678);
    chk("oor_after_err", {63'd0, er}, 64'd0);
    txn(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("mis_h_nowrite", rd, 64'h11223344AB667788);

    // Reset during WAIT aborts a store
    txn(1'b1, 64'h20, 2'd3, 1'b0, 64'h0123456789ABCDEF, rd, er, lat);
    txn(1'b0, 64'h20, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("pre_rst_ld", rd, 64'h0123456789ABCDEF);
    @(negedge Clk);
    a_req_we = 1'b1; a_req_addr = 64'h20; a_req_size = 2'd3; a_req_wdata = 64'hDEADBEEFDEADBEEF;
    a_req_valid = 1'b1;
    @(posedge Clk);
    #1 a_req_valid = 1'b0;
    chk("wait_ready", {63'd0, a_req_ready}, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("mid_rst_ready", {63'd0, a_req_ready}, 64'd1);
    chk("mid_rst_rdata", a_resp_rdata, 64'd0);
    chk("mid_rst_valid", {63'd0, a_resp_valid}, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk);
      #1;
      if (a_resp_valid) pulses++;
    end
    chk("rst_no_pulse", 64'(pulses), 64'd0);
    txn(1'b0, 64'h20, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("rst_nowrite", rd, 64'h0123456789ABCDEF);

    // LATENCY=0 instance: store, then two loads with req_valid held high
    @(negedge Clk);
    b_req_we = 1'b1; b_req_addr = 64'h8; b_req_size = 2'd3; b_req_wdata = 64'hF0;
    b_req_valid = 1'b1;
    @(posedge Clk);
    #1 b_req_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("b_st_valid", {63'd0, b_resp_valid}, 64'd1);
    chk("b_st_err", {63'd0, b_resp_err}, 64'd0);
    @(negedge Clk);
    b_req_we = 1'b0; b_req_addr = 64'h8; b_req_size = 2'd0; b_req_unsigned = 1'b0;
    b_req_valid = 1'b1;
    rv_bits = 6'd0; rr_bits = 6'd0; rd_first = 64'd0; rd_second = 64'd0;
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk);
      #1;
      if (k == 0) b_req_unsigned = 1'b1;
      if (k == 3) b_req_valid = 1'b0;
      rv_bits[k] = b_resp_valid;
      rr_bits[k] = b_req_ready;
      if (k == 2) rd_first = b_resp_rdata;
      if (k == 5) rd_second = b_resp_rdata;
    end
    chk("b2b_valid", {58'd0, rv_bits}, 64'h24);
    chk("b2b_ready", {58'd0, rr_bits}, 64'h24);
    chk("b2b_rd1", rd_first, 64'hFFFFFFFFFFFFFFF0);
    chk("b2b_rd2", rd_second, 64'h00000000000000F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem64_responder.md
Name: mem64_responder

Overview:
- Memory-side responder for the multicycle RISC-V core's data port; it is the slave end of the core's 64-bit load/store interface.
- Accepts one request at a time through a valid/ready handshake and models a configurable access latency.
- Performs sub-word stores by read-modify-write on an internal array of 64-bit words.
- Returns loads already sign- or zero-extended, plus an error flag for misaligned or out-of-range addresses.

Parameters:
DEPTH_WORDS, 256, number of 64-bit words in storage (power of two, >=2); AW = log2(DEPTH_WORDS)
LATENCY, 2, extra wait cycles between accept and array access (0..15)

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_addr  in  64  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=double
req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
req_wdata  in  64  store data, right-aligned (bits [8*2^size-1:0] used)
resp_valid  out  1  one-cycle response pulse, no backpressure
resp_rdata  out  64  extended load data; 0 for stores and errors
resp_err  out  1  qualified by resp_valid; 1 = misaligned or out of range

Behaviour:
- Interface: one clock Clk; reset Reset is asynchronous and active-high.
- Reset (async, any state): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, internal request latches=0, wait counter=0. Array contents are not cleared. A request aborted by reset before COMMIT never writes the array.
- FSM states: IDLE, WAIT, ACCESS, COMMIT.
- IDLE: req_ready=1. When req_valid&&req_ready at an edge, latch we/addr/size/unsigned/wdata and go to WAIT if LATENCY>0 (counter loaded with LATENCY-1), else to ACCESS. Without req_valid, stay in IDLE.
- WAIT: req_ready=0. Decrement the counter; go to ACCESS when it is 0. The state is held exactly LATENCY cycles.
- ACCESS: compute err and read array[word index] into the merge buffer. Word index = addr[AW+2:3]. Lane offset = addr[2:0]*8 (little-endian).
- Error conditions:
  - misaligned: size1 with addr[0]!=0; size2 with addr[1:0]!=0; size3 with addr[2:0]!=0
  - out of range: any of addr[63:AW+3] nonzero
- COMMIT: exactly one of the following, then go to IDLE.
  - Store, no err: write the merged word. Bytes covered by the size and lane take wdata; all other bytes keep the buffer value.
  - Load, no err: select the lane and sign/zero-extend per req_unsigned; size3 ignores req_unsigned.
  - err: no array write.
  - In all cases, register resp_valid=1, resp_err=err, resp_rdata (0 for store or err).
- resp_valid is high for exactly one cycle, coinciding with the first IDLE cycle after COMMIT; otherwise 0.
- resp_rdata and resp_err hold their value until the next response.
- Latency: handshake at edge ending cycle T gives resp_valid high in cycle T+LATENCY+3.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high. Throughput is one request per LATENCY+3 cycles.
- req_valid dropped before acceptance: nothing happens. Request inputs are ignored outside IDLE.
- A load after a store to the same word always sees the stored data (strictly sequential, no forwarding hazard).

Test Plan:
1. LATENCY=2, no errors: store size3 addr=0x10 wdata=0x1122334455667788 accepted cycle T -> resp_valid at T+5, err=0, rdata=0. Then load size3 addr=0x10 -> rdata=0x1122334455667788.
2. Byte merge: after (1), store size0 addr=0x13 wdata=0xAB; load size3 addr=0x10 -> rdata=0x11223344AB667788.
3. Extension: load size0 addr=0x13 unsigned=0 -> 0xFFFFFFFFFFFFFFAB; unsigned=1 -> 0xAB. Load size1 addr=0x12 unsigned=0 -> 0xFFFFFFFFFFFFAB66.
4. Errors: load size2 addr=0x12 -> err=1, rdata=0. Store size3 addr=0x800 with DEPTH=256 -> err=1 and array unchanged (later load of 0x0 returns the prior value).
5. Reset mid-operation: store accepted, Reset asserted during WAIT -> outputs 0 immediately, req_ready=1, no resp_valid pulse, target word unchanged.
6. Back-to-back and LATENCY=0: two loads with req_valid held high -> responses 3 cycles apart, req_ready low for exactly 2 cycles between accepts.
